// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for a shared 8-deep fifo: round-robin grant with burst locking,
// a registered write beat, and throttling from the fifo occupancy so a full fifo is never written.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 4,
    parameter int MAX_BURST = 4,
    localparam int OWN_W    = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        gnt_o,
    input  logic [CNT_W-1:0]        fifo_cnt_i,
    output logic                    fifo_wr_o,
    output logic [DATA_W-1:0]       fifo_din_o,
    output logic [OWN_W-1:0]        owner_o,
    output logic                    busy_o
);

    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0]  MAX_BC  = BC_W'(MAX_BURST);
    localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);
    localparam logic [OWN_W:0]   N_C     = (OWN_W+1)'(N_REQ);
    localparam logic [OWN_W-1:0] LAST_C  = OWN_W'(N_REQ - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q;
    logic [OWN_W-1:0]  owner_q;
    logic [OWN_W-1:0]  rr_ptr_q;
    logic [BC_W-1:0]   beat_cnt_q;
    logic              fifo_wr_q;
    logic [DATA_W-1:0] fifo_din_q;

    logic              space;
    logic              keep_lock;
    logic              found;
    logic              any_gnt;
    logic [OWN_W-1:0]  owner_inc;
    logic [OWN_W-1:0]  scan_start;
    logic [OWN_W-1:0]  win;
    logic [OWN_W-1:0]  grant_idx;
    logic [OWN_W:0]    cand;
    logic [N_REQ-1:0]  gnt;

    // The beat already on fifo_wr is not yet counted by the fifo, so it reserves a slot.
    assign space     = ({1'b0, fifo_cnt_i} + {{CNT_W{1'b0}}, fifo_wr_q}) < DEPTH_C;
    assign owner_inc = (owner_q == LAST_C) ? '0 : owner_q + OWN_W'(1);

    always_comb begin
        keep_lock  = (state_q == BURST) && req_i[owner_q] && (beat_cnt_q < MAX_BC);
        scan_start = (state_q == BURST) ? owner_inc : rr_ptr_q;
        found      = 1'b0;
        win        = scan_start;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, scan_start} + (OWN_W+1)'(k);
            if (cand >= N_C) begin
                cand = cand - N_C;
            end
            if (!found && req_i[cand[OWN_W-1:0]]) begin
                found = 1'b1;
                win   = cand[OWN_W-1:0];
            end
        end
        gnt = '0;
        if (rst_i) begin
            gnt = '0;
        end else if (keep_lock) begin
            if (space) begin
                gnt[owner_q] = 1'b1;
            end
        end else if (found && space) begin
            gnt[win] = 1'b1;
        end
    end

    assign any_gnt   = |gnt;
    assign grant_idx = keep_lock ? owner_q : win;

    // A release re-arbitrates in the same cycle; with no winner the FSM drops back to IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_din_q <= '0;
        end else begin
            fifo_wr_q <= any_gnt;
            if (any_gnt) begin
                fifo_din_q <= req_data_i[grant_idx*DATA_W +: DATA_W];
            end
            case (state_q)
                IDLE: begin
                    if (any_gnt) begin
                        state_q    <= BURST;
                        owner_q    <= win;
                        beat_cnt_q <= BC_ONE;
                    end
                end
                BURST: begin
                    if (keep_lock) begin
                        if (any_gnt) begin
                            beat_cnt_q <= beat_cnt_q + BC_ONE;
                        end
                    end else begin
                        rr_ptr_q <= owner_inc;
                        if (any_gnt) begin
                            owner_q    <= win;
                            beat_cnt_q <= BC_ONE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o      = gnt;
    assign fifo_wr_o  = fifo_wr_q;
    assign fifo_din_o = fifo_din_q;
    assign owner_o    = owner_q;
    assign busy_o     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter: a behavioural arbiter/fifo model predicts grants,
// accepted beats are queued and a negedge monitor checks every fifo write against that queue.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int MAXB  = 4;
    localparam int OW    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] reqData;
    logic [N-1:0]    gnt;
    logic [CW-1:0]   fifoCnt;
    logic            fifoWr;
    logic [DW-1:0]   fifoDin;
    logic [OW-1:0]   owner;
    logic            busy;

    fifo_wr_arbiter #(
        .N_REQ(N), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .MAX_BURST(MAXB)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(reqData), .gnt_o(gnt),
        .fifo_cnt_i(fifoCnt), .fifo_wr_o(fifoWr), .fifo_din_o(fifoDin),
        .owner_o(owner), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sbq[$];

    bit            reqOn[N];
    logic [DW-1:0] reqVal[N];
    int            holdOff[N];
    bit            mLocked;
    int            mOwner;
    int            mBeats;
    int            mPtr;
    int            mFifo;
    bit            mWrPipe;
    int            expWin;
    int            readPct;
    bit            quiet;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every DUT write must match the oldest accepted beat and must never target a full fifo.
    always @(negedge clk) begin
        if (rst === 1'b0 && fifoWr === 1'b1) begin
            check("wr_into_full", (int'(fifoCnt) >= DEPTH) ? 1 : 0, 0);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL fifo_din unexpected write actual=%0d expected=none at %0t",
                         fifoDin, $time);
            end else begin
                check("fifo_din", int'(fifoDin), int'(sbq.pop_front()));
            end
        end
    end

    function automatic int modelWinner();
        int start;
        bit space;
        space = (mFifo + int'(mWrPipe)) < DEPTH;
        if (mLocked && reqOn[mOwner] && mBeats < MAXB) begin
            return space ? mOwner : -1;
        end
        if (!space) begin
            return -1;
        end
        start = mLocked ? (mOwner + 1) % N : mPtr;
        for (int k = 0; k < N; k++) begin
            if (reqOn[(start + k) % N]) begin
                return (start + k) % N;
            end
        end
        return -1;
    endfunction

    function automatic void modelReset();
        mLocked = 0;
        mOwner  = 0;
        mBeats  = 0;
        mPtr    = 0;
        mFifo   = 0;
        mWrPipe = 0;
        sbq.delete();
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (!reqOn[i]) begin
                if (holdOff[i] > 0) begin
                    holdOff[i]--;
                end else if (!quiet && $urandom_range(99) < 60) begin
                    reqOn[i]  = 1'b1;
                    reqVal[i] = DW'($urandom);
                end
            end
            req[i]              = reqOn[i];
            reqData[i*DW +: DW] = reqVal[i];
        end
        fifoCnt = CW'(mFifo);
        expWin  = modelWinner();
    endtask

    task automatic checkOutput();
        check("gnt", int'(gnt), (expWin >= 0) ? (1 << expWin) : 0);
        check("busy", int'(busy), int'(mLocked));
        check("owner", int'(owner), mOwner);
    endtask

    // Advances the model across one posedge using the grant it predicted for this cycle.
    task automatic modelStep();
        bit keep;
        bit rd;
        keep  = mLocked && reqOn[mOwner] && mBeats < MAXB;
        rd    = (mFifo > 0) && ($urandom_range(99) < readPct);
        mFifo = mFifo + int'(mWrPipe) - int'(rd);
        mWrPipe = (expWin >= 0);
        if (!mLocked) begin
            if (expWin >= 0) begin
                mLocked = 1;
                mOwner  = expWin;
                mBeats  = 1;
            end
        end else if (keep) begin
            if (expWin >= 0) mBeats++;
        end else begin
            mPtr = (mOwner + 1) % N;
            if (expWin >= 0) begin
                mOwner = expWin;
                mBeats = 1;
            end else begin
                mLocked = 0;
            end
        end
        if (expWin >= 0) begin
            sbq.push_back(reqVal[expWin]);
            if (!quiet && $urandom_range(99) < 70) begin
                reqVal[expWin] = DW'($urandom);
            end else begin
                reqOn[expWin]   = 1'b0;
                holdOff[expWin] = $urandom_range(2);
            end
        end
    endtask

    task automatic asyncResetCheck();
        #2;
        rst = 1'b1;
        #1;
        check("rst_gnt", int'(gnt), 0);
        check("rst_fifo_wr", int'(fifoWr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_owner", int'(owner), 0);
        check("rst_fifo_din", int'(fifoDin), 0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic runCycle();
        applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        reqData = '0;
        fifoCnt = '0;
        quiet   = 0;
        readPct = 50;
        for (int i = 0; i < N; i++) begin
            reqOn[i]   = 0;
            reqVal[i]  = '0;
            holdOff[i] = 0;
        end
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt", int'(gnt), 0);
        check("reset_fifo_wr", int'(fifoWr), 0);
        check("reset_fifo_din", int'(fifoDin), 0);
        check("reset_owner", int'(owner), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;

        for (int cyc = 0; cyc < 2400; cyc++) begin
            case ((cyc / 200) % 3)
                0:       readPct = 50;
                1:       readPct = 10;
                default: readPct = 95;
            endcase
            if (cyc % 300 == 157) begin
                asyncResetCheck();
            end
            runCycle();
        end

        quiet   = 1;
        readPct = 100;
        for (int cyc = 0; cyc < 60; cyc++) begin
            runCycle();
        end
        check("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
